// File: rtl/bit_stuff_pkg.sv
// Shared definitions for the transmit-side bit stuffer.
// Contents: FSM state type, default run length and the ones-counter
// width derivation used by bit_stuffer and ones_run_counter.
package bit_stuff_pkg;

  typedef enum logic [0:0] {
    PASS  = 1'b0,
    STUFF = 1'b1
  } state_t;

  localparam int RUN_LEN_DEFAULT = 5;

  // Counter must hold values 0..run_len, hence run_len+1 codes.
  function automatic int cnt_width(input int run_len);
    return $clog2(run_len + 1);
  endfunction

endpackage

// File: rtl/bit_stuffer_ones_run_counter.sv
// Counter of consecutive 1s seen in the current frame.
// Ports:
//   clk     - clock, all state on rising edge
//   reset   - asynchronous active-low reset
//   clr_i   - clear the count (has priority over inc_i)
//   inc_i   - increment the count
//   cnt_o   - current count
//   hit_o   - the next 1 would complete a run of RUN_LEN
module ones_run_counter
  import bit_stuff_pkg::*;
#(
  parameter int RUN_LEN = RUN_LEN_DEFAULT,
  parameter int CNT_W   = cnt_width(RUN_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             hit_o
);

  localparam logic [CNT_W:0] RUN_LEN_W = RUN_LEN[CNT_W:0];

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W:0]   cnt_plus1_s;

  // One extra bit so the compare against RUN_LEN cannot wrap.
  assign cnt_plus1_s = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign hit_o       = (cnt_plus1_s == RUN_LEN_W);
  assign cnt_o       = cnt_q;

  // Next-count selection: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc_i) begin
      cnt_d = cnt_plus1_s[CNT_W-1:0];
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bit_stuffer.sv
// Transmit-side bit stuffer: inserts one 0 after every RUN_LEN consecutive
// 1s of a framed 1-bit stream. Output is a single registered stage that
// holds under backpressure.
// Ports:
//   clk, reset                - clock, asynchronous active-low reset
//   in_valid/in_ready         - input handshake (in_ready combinational)
//   in_bit, in_last           - data bit and end-of-frame marker
//   out_valid/out_ready       - output handshake (out_valid registered)
//   out_bit, out_last         - registered data/stuffed bit and end-of-frame
//   out_stuffed               - registered flag: current bit is an inserted 0
module bit_stuffer
  import bit_stuff_pkg::*;
#(
  parameter int RUN_LEN = RUN_LEN_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  input  logic in_last,
  output logic out_valid,
  input  logic out_ready,
  output logic out_bit,
  output logic out_last,
  output logic out_stuffed
);

  localparam int CNT_W = cnt_width(RUN_LEN);

  state_t           state_q;
  logic             last_pend_q;
  logic             out_valid_q;
  logic             out_bit_q;
  logic             out_last_q;
  logic             out_stuffed_q;

  logic             slot_free_s;
  logic             accept_s;
  logic             cnt_clr_s;
  logic             cnt_inc_s;
  logic             cnt_hit_s;
  logic [CNT_W-1:0] ones_cnt_s;

  assign slot_free_s = !out_valid_q || out_ready;
  assign in_ready    = reset && (state_q == PASS) && slot_free_s;
  assign accept_s    = in_valid && in_ready;

  assign out_valid   = out_valid_q;
  assign out_bit     = out_bit_q;
  assign out_last    = out_last_q;
  assign out_stuffed = out_stuffed_q;

  // Counter control: a 1 that does not end the run or frame extends the run;
  // anything else accepted (0, end of frame, run completion) restarts it.
  always_comb begin
    cnt_clr_s = 1'b0;
    cnt_inc_s = 1'b0;
    if ((state_q == PASS) && accept_s) begin
      if (in_bit && !cnt_hit_s && !in_last) begin
        cnt_inc_s = 1'b1;
      end else begin
        cnt_clr_s = 1'b1;
      end
    end else if ((state_q == STUFF) && slot_free_s) begin
      cnt_clr_s = 1'b1;
    end else begin
      cnt_clr_s = 1'b0;
    end
  end

  ones_run_counter #(
    .RUN_LEN (RUN_LEN),
    .CNT_W   (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr_s),
    .inc_i (cnt_inc_s),
    .cnt_o (ones_cnt_s),
    .hit_o (cnt_hit_s)
  );

  // FSM and output register; a full, stalled output freezes everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= PASS;
      last_pend_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      out_bit_q     <= 1'b0;
      out_last_q    <= 1'b0;
      out_stuffed_q <= 1'b0;
    end else begin
      case (state_q)
        PASS: begin
          if (accept_s) begin
            out_valid_q   <= 1'b1;
            out_bit_q     <= in_bit;
            out_stuffed_q <= 1'b0;
            if (in_bit && cnt_hit_s) begin
              // End-of-frame moves onto the stuffed 0 that follows.
              state_q     <= STUFF;
              last_pend_q <= in_last;
              out_last_q  <= 1'b0;
            end else begin
              out_last_q  <= in_last;
            end
          end else if (slot_free_s) begin
            out_valid_q <= 1'b0;
          end else begin
            out_valid_q <= out_valid_q;
          end
        end
        STUFF: begin
          if (slot_free_s) begin
            out_valid_q   <= 1'b1;
            out_bit_q     <= 1'b0;
            out_stuffed_q <= 1'b1;
            out_last_q    <= last_pend_q;
            last_pend_q   <= 1'b0;
            state_q       <= PASS;
          end else begin
            state_q <= STUFF;
          end
        end
        default: begin
          state_q     <= PASS;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_stuffer.sv
// Directed self-checking bench for bit_stuffer (RUN_LEN = 5).
module tb_bit_stuffer;
  import bit_stuff_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready, in_bit, in_last;
  logic out_valid, out_ready, out_bit, out_last, out_stuffed;

  int vectors = 0;
  int miscompares = 0;

  // Output capture: first captured bit ends up most significant.
  logic [15:0] cap_bits, cap_last, cap_stf;
  int cap_n;
  int stall_cnt;

  bit_stuffer #(.RUN_LEN(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_last(out_last), .out_stuffed(out_stuffed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      cap_bits = {cap_bits[14:0], out_bit};
      cap_last = {cap_last[14:0], out_last};
      cap_stf  = {cap_stf[14:0], out_stuffed};
      cap_n    = cap_n + 1;
    end
    if (reset && in_valid && !in_ready) stall_cnt = stall_cnt + 1;
  end

  task automatic clear_cap();
    cap_bits = 16'h0000; cap_last = 16'h0000; cap_stf = 16'h0000;
    cap_n = 0; stall_cnt = 0;
  endtask

  task automatic send(input logic b, input logic l);
    int guard;
    guard = 0;
    in_valid = 1'b1; in_bit = b; in_last = l;
    @(negedge clk);
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: in_ready stuck at %0b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({out_valid, out_bit, out_last, out_stuffed} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required 0000", {out_valid, out_bit, out_last, out_stuffed});
    end
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    vectors++;
    if (dut.ones_cnt_s !== 3'd0 || dut.state_q !== PASS) begin
      miscompares++;
      $display("FAIL reset_state: cnt %0d state %0d required 0 0", dut.ones_cnt_s, dut.state_q);
    end
  endtask

  task automatic test_run_across_stuff();
    clear_cap();
    for (int i = 0; i < 7; i++) send(1'b1, (i == 6) ? 1'b1 : 1'b0);
    drain();
    vectors++;
    if (cap_n !== 8 || cap_bits !== 16'h00FB) begin
      miscompares++;
      $display("FAIL across_bits: n=%0d bits=%h required n=8 bits=00fb", cap_n, cap_bits);
    end
    vectors++;
    if (cap_stf !== 16'h0004 || cap_last !== 16'h0001) begin
      miscompares++;
      $display("FAIL across_flags: stuffed=%h last=%h required 0004 0001", cap_stf, cap_last);
    end
    vectors++;
    if (stall_cnt !== 1) begin
      miscompares++;
      $display("FAIL across_stall: %0d cycles in_ready low, required 1", stall_cnt);
    end
  endtask

  task automatic test_run_ends_frame();
    clear_cap();
    for (int i = 0; i < 5; i++) send(1'b1, (i == 4) ? 1'b1 : 1'b0);
    drain();
    vectors++;
    if (cap_n !== 6 || cap_bits !== 16'h003E) begin
      miscompares++;
      $display("FAIL ends_bits: n=%0d bits=%h required n=6 bits=003e", cap_n, cap_bits);
    end
    vectors++;
    if (cap_stf !== 16'h0001 || cap_last !== 16'h0001) begin
      miscompares++;
      $display("FAIL ends_flags: stuffed=%h last=%h required 0001 0001", cap_stf, cap_last);
    end
    vectors++;
    if (dut.ones_cnt_s !== 3'd0) begin
      miscompares++;
      $display("FAIL ends_cnt: got %0d required 0", dut.ones_cnt_s);
    end
  endtask

  task automatic test_zero_clears();
    logic [9:0] stim;
    stim = 10'b1101111100;
    clear_cap();
    for (int i = 9; i >= 0; i--) send(stim[i], (i == 0) ? 1'b1 : 1'b0);
    drain();
    vectors++;
    if (cap_n !== 11 || cap_bits !== 16'h06F8) begin
      miscompares++;
      $display("FAIL zero_bits: n=%0d bits=%h required n=11 bits=06f8", cap_n, cap_bits);
    end
    vectors++;
    if (cap_stf !== 16'h0004 || cap_last !== 16'h0001) begin
      miscompares++;
      $display("FAIL zero_flags: stuffed=%h last=%h required 0004 0001", cap_stf, cap_last);
    end
  endtask

  task automatic test_backpressure_stuff();
    clear_cap();
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_bit = 1'b0; in_last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({out_valid, out_bit, out_last, out_stuffed, in_ready} !== 5'b11000 || dut.state_q !== STUFF) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: v/b/l/s/rdy=%b state=%0d required 11000 state=1",
                 c, {out_valid, out_bit, out_last, out_stuffed, in_ready}, dut.state_q);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({out_valid, out_bit, out_stuffed, out_last, in_ready} !== 5'b10101) begin
      miscompares++;
      $display("FAIL bp_release: v/b/s/l/rdy=%b required 10101",
               {out_valid, out_bit, out_stuffed, out_last, in_ready});
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
    drain();
    vectors++;
    if (cap_n !== 7 || cap_bits !== 16'h007C || cap_stf !== 16'h0002 || cap_last !== 16'h0001) begin
      miscompares++;
      $display("FAIL bp_stream: n=%0d bits=%h stuffed=%h last=%h required 7 007c 0002 0001",
               cap_n, cap_bits, cap_stf, cap_last);
    end
  endtask

  task automatic test_reset_mid_stuff();
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0);
    reset = 1'b0;
    #1;
    clear_cap();
    vectors++;
    if ({out_valid, out_bit, out_last, out_stuffed} !== 4'b0000 || dut.state_q !== PASS) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: %b state=%0d required 0000 state=0",
               {out_valid, out_bit, out_last, out_stuffed}, dut.state_q);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (cap_n !== 0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_quiet: n=%0d out_valid=%b required 0 0", cap_n, out_valid);
    end
    clear_cap();
    for (int i = 0; i < 5; i++) send(1'b1, (i == 4) ? 1'b1 : 1'b0);
    drain();
    vectors++;
    if (cap_n !== 6 || cap_bits !== 16'h003E || cap_stf !== 16'h0001 || cap_last !== 16'h0001) begin
      miscompares++;
      $display("FAIL rst_mid_next: n=%0d bits=%h stuffed=%h last=%h required 6 003e 0001 0001",
               cap_n, cap_bits, cap_stf, cap_last);
    end
  endtask

  task automatic test_frame_boundary();
    clear_cap();
    for (int i = 0; i < 3; i++) send(1'b1, (i == 2) ? 1'b1 : 1'b0);
    for (int i = 0; i < 2; i++) send(1'b1, (i == 1) ? 1'b1 : 1'b0);
    drain();
    vectors++;
    if (cap_n !== 5 || cap_bits !== 16'h001F) begin
      miscompares++;
      $display("FAIL boundary_bits: n=%0d bits=%h required n=5 bits=001f", cap_n, cap_bits);
    end
    vectors++;
    if (cap_stf !== 16'h0000 || cap_last !== 16'h0005) begin
      miscompares++;
      $display("FAIL boundary_flags: stuffed=%h last=%h required 0000 0005", cap_stf, cap_last);
    end
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    clear_cap();
    test_reset();
    test_run_across_stuff();
    test_run_ends_frame();
    test_zero_clears();
    test_backpressure_stuff();
    test_reset_mid_stuff();
    test_frame_boundary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
